// File: rtl/midi_voice_table_if.sv
`default_nettype none
// ============================================================================
//  Module      : midi_voice_table_if
//  Description : Bundles the event handshake, free-slot feedback, slot
//                status, alloc/release pulses, drop counter and slot read
//                port of midi_voice_table.
//                  slave  - view taken by midi_voice_table
//                  master - view taken by the decoder / scanner / voices side
//  Revision    : 1.0  initial release
// ============================================================================
interface midi_voice_table_if #(
    parameter int VOICES = 32,
    parameter int IDX_W  = 5,
    parameter int KEY_W  = 7
);
    // Event handshake from the MIDI event decoder
    logic              ev_valid;
    logic              ev_ready;
    logic              ev_note_on;
    logic [KEY_W-1:0]  ev_key;
    logic [KEY_W-1:0]  ev_vel;
    logic              all_off;

    // Slot status loop with next_midi_note
    logic [IDX_W-1:0]  free_slot;
    logic [VOICES-1:0] notes_playing;

    // Voice start/stop notifications
    logic              alloc_valid;
    logic [IDX_W-1:0]  alloc_slot;
    logic              release_valid;
    logic [IDX_W-1:0]  release_slot;
    logic [7:0]        drop_count;

    // Registered per-slot read port
    logic [IDX_W-1:0]  rd_slot;
    logic [KEY_W-1:0]  rd_key;
    logic [KEY_W-1:0]  rd_vel;

    modport slave (
        input  ev_valid, ev_note_on, ev_key, ev_vel, all_off, free_slot, rd_slot,
        output ev_ready, notes_playing, alloc_valid, alloc_slot,
               release_valid, release_slot, drop_count, rd_key, rd_vel
    );

    modport master (
        output ev_valid, ev_note_on, ev_key, ev_vel, all_off, free_slot, rd_slot,
        input  ev_ready, notes_playing, alloc_valid, alloc_slot,
               release_valid, release_slot, drop_count, rd_key, rd_vel
    );
endinterface
`default_nettype wire

// File: rtl/midi_voice_table.sv
`default_nettype none
// ============================================================================
//  Module      : midi_voice_table
//  Description : Voice-slot table between the MIDI event decoder and
//                next_midi_note. Note-on/off events are matched against the
//                busy slots by a one-slot-per-cycle linear scan; a miss on a
//                note-on allocates the slot reported by next_midi_note.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk    in  system clock, all state on rising edge
//    reset  in  asynchronous active-high reset, clears all state
//    bus    midi_voice_table_if.slave
//             ev_valid/ev_ready/ev_note_on/ev_key/ev_vel : event handshake
//             all_off         : panic, releases every slot silently
//             free_slot       : first free slot from next_midi_note
//             notes_playing   : bit i set = slot i busy
//             alloc_valid/slot, release_valid/slot : 1-cycle pulses
//             drop_count      : saturating count of dropped events
//             rd_slot -> rd_key/rd_vel : 1-cycle registered read
//
//  Build option
//    VOICE_STEAL_EN  defined   : a note-on into a full table steals slots
//                                round-robin from steal_ptr
//                    undefined : a note-on into a full table is dropped
// ============================================================================
module midi_voice_table #(
    parameter int VOICES = 32,
    parameter int IDX_W  = 5,
    parameter int KEY_W  = 7
) (
    input  logic               clk,
    input  logic               reset,
    midi_voice_table_if.slave  bus
);

    localparam logic [IDX_W-1:0] c_LAST_SLOT = IDX_W'(VOICES - 1);
    localparam logic [5:0]       c_WAIT_LAST = 6'd63;   // 64th wait cycle
    localparam logic [7:0]       c_DROP_MAX  = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_ALLOC  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    // Captured event
    logic              r_ev_on;
    logic [KEY_W-1:0]  r_ev_key;
    logic [KEY_W-1:0]  r_ev_vel;

    logic [IDX_W-1:0]  r_scan;
    logic [5:0]        r_wait;

    logic [VOICES-1:0] r_notes;
    logic [KEY_W-1:0]  r_key_tab [VOICES];
    logic [KEY_W-1:0]  r_vel_tab [VOICES];

    logic              r_alloc_valid;
    logic [IDX_W-1:0]  r_alloc_slot;
    logic              r_release_valid;
    logic [IDX_W-1:0]  r_release_slot;
    logic [7:0]        r_drop_cnt;
    logic [KEY_W-1:0]  r_rd_key;
    logic [KEY_W-1:0]  r_rd_vel;

    // Decision strobes produced by the next-state logic
    logic              w_accept;
    logic              w_do_release;
    logic              w_do_retrig;
    logic              w_do_alloc;
    logic              w_do_steal;
    logic              w_do_drop;

    logic              w_match;
    logic              w_full;
    logic              w_free_busy;
    logic [IDX_W-1:0]  w_steal_idx;
    logic              w_wr_en;
    logic [IDX_W-1:0]  w_wr_idx;

    assign w_match     = r_notes[r_scan] && (r_key_tab[r_scan] == r_ev_key);
    assign w_full      = &r_notes;
    // next_midi_note lags one cycle behind notes_playing; a busy bit here
    // means its answer is stale, not that the table is full.
    assign w_free_busy = r_notes[bus.free_slot];

    // ------------------------------------------------------------------
    // Round-robin steal pointer (only present with voice stealing)
    // ------------------------------------------------------------------
`ifdef VOICE_STEAL_EN
    logic [IDX_W-1:0] r_steal_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_steal_ptr <= '0;
        end else if (w_do_steal) begin
            r_steal_ptr <= (r_steal_ptr == c_LAST_SLOT) ? '0 : r_steal_ptr + 1'b1;
        end
    end

    assign w_steal_idx = r_steal_ptr;
`else
    assign w_steal_idx = '0;
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and decision strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_do_release = 1'b0;
        w_do_retrig  = 1'b0;
        w_do_alloc   = 1'b0;
        w_do_steal   = 1'b0;
        w_do_drop    = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (bus.ev_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SEARCH;
                end
            end

            S_SEARCH: begin
                if (w_match) begin
                    // Keys are unique in the table, so the first hit ends the scan
                    if (r_ev_on) begin
                        w_do_retrig = 1'b1;
                    end else begin
                        w_do_release = 1'b1;
                    end
                    w_state_nxt = S_IDLE;
                end else if (r_scan == c_LAST_SLOT) begin
                    // A note-off for a key that is not playing is ignored
                    w_state_nxt = r_ev_on ? S_ALLOC : S_IDLE;
                end
            end

            S_ALLOC: begin
                if (w_full) begin
`ifdef VOICE_STEAL_EN
                    w_do_steal = 1'b1;
`else
                    w_do_drop  = 1'b1;
`endif
                    w_state_nxt = S_IDLE;
                end else if (!w_free_busy) begin
                    w_do_alloc  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_wait == c_WAIT_LAST) begin
                    // Scanner never settled: give up on this event
                    w_do_drop   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Panic overrides everything, including an accept in the same cycle
        if (bus.all_off) begin
            w_accept     = 1'b0;
            w_do_release = 1'b0;
            w_do_retrig  = 1'b0;
            w_do_alloc   = 1'b0;
            w_do_steal   = 1'b0;
            w_do_drop    = 1'b0;
            w_state_nxt  = S_IDLE;
        end
    end

    // Single table write port shared by retrigger, allocation and steal
    assign w_wr_en  = w_do_retrig | w_do_alloc | w_do_steal;
    assign w_wr_idx = w_do_retrig ? r_scan :
                      w_do_steal  ? w_steal_idx : bus.free_slot;

    // ------------------------------------------------------------------
    // Event capture, scan index and wait counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ev_on  <= 1'b0;
            r_ev_key <= '0;
            r_ev_vel <= '0;
            r_scan   <= '0;
            r_wait   <= '0;
        end else begin
            if (w_accept) begin
                // Note-on with zero velocity is a note-off by MIDI convention
                r_ev_on  <= bus.ev_note_on && (bus.ev_vel != '0);
                r_ev_key <= bus.ev_key;
                r_ev_vel <= bus.ev_vel;
                r_scan   <= '0;
            end else if (r_state == S_SEARCH) begin
                r_scan   <= r_scan + 1'b1;
            end
            // Zero on entry to ALLOC, since it is only reached from SEARCH
            r_wait <= (r_state == S_ALLOC) ? r_wait + 6'd1 : '0;
        end
    end

    // ------------------------------------------------------------------
    // Slot status and key/velocity table
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_notes <= '0;
            for (int i = 0; i < VOICES; i++) begin
                r_key_tab[i] <= '0;
                r_vel_tab[i] <= '0;
            end
        end else begin
            if (bus.all_off) begin
                r_notes <= '0;
            end else begin
                if (w_do_release) begin
                    r_notes[r_scan] <= 1'b0;
                end
                if (w_do_alloc) begin
                    r_notes[bus.free_slot] <= 1'b1;
                end
            end
            if (w_wr_en) begin
                r_key_tab[w_wr_idx] <= r_ev_key;
                r_vel_tab[w_wr_idx] <= r_ev_vel;
            end
        end
    end

    // ------------------------------------------------------------------
    // Notification pulses and drop counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alloc_valid   <= 1'b0;
            r_alloc_slot    <= '0;
            r_release_valid <= 1'b0;
            r_release_slot  <= '0;
            r_drop_cnt      <= '0;
        end else begin
            r_alloc_valid   <= w_wr_en;
            r_release_valid <= w_do_release | w_do_steal;
            if (w_wr_en) begin
                r_alloc_slot <= w_wr_idx;
            end
            if (w_do_release) begin
                r_release_slot <= r_scan;
            end else if (w_do_steal) begin
                r_release_slot <= w_steal_idx;
            end
            if (w_do_drop && (r_drop_cnt != c_DROP_MAX)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered read port for the synth voices
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_key <= '0;
            r_rd_vel <= '0;
        end else begin
            r_rd_key <= r_key_tab[bus.rd_slot];
            r_rd_vel <= r_vel_tab[bus.rd_slot];
        end
    end

    assign bus.ev_ready      = (r_state == S_IDLE);
    assign bus.notes_playing = r_notes;
    assign bus.alloc_valid   = r_alloc_valid;
    assign bus.alloc_slot    = r_alloc_slot;
    assign bus.release_valid = r_release_valid;
    assign bus.release_slot  = r_release_slot;
    assign bus.drop_count    = r_drop_cnt;
    assign bus.rd_key        = r_rd_key;
    assign bus.rd_vel        = r_rd_vel;

endmodule
`default_nettype wire
